// File: rtl/reg_file.sv
// General-purpose register file: DEPTH x WIDTH flip-flops, two combinational read ports,
// one writeback port plus a call-link port that owns LINK_REG on a collision.
module reg_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             link_en,
  input  logic [WIDTH-1:0] link_data
);

  localparam logic [5:0] DEPTH_W = 6'(DEPTH);

  logic [WIDTH-1:0] regs_r [DEPTH];

  // Read port A: addresses beyond DEPTH return zero; register 0 is held at zero.
  always_comb begin
    rs_data = '0;
    if ({1'b0, rs_addr} < DEPTH_W) begin
      rs_data = regs_r[rs_addr];
    end else begin
      rs_data = '0;
    end
  end

  // Read port B, identical to port A.
  always_comb begin
    rt_data = '0;
    if ({1'b0, rt_addr} < DEPTH_W) begin
      rt_data = regs_r[rt_addr];
    end else begin
      rt_data = '0;
    end
  end

  // Register update; the link write wins over writeback when both target LINK_REG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      regs_r[0] <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        if (link_en && (i == LINK_REG)) begin
          regs_r[i] <= link_data;
        end else if (wr_en && (wr_addr == 5'(i))) begin
          regs_r[i] <= wr_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed and model-based checks for reg_file: reset, writes, register 0,
// link collisions, hold, asynchronous reset and a 10k-cycle random regression.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        link_en;
  logic [31:0] link_data;

  int vectors;
  int miscompares;

  reg_file #(.WIDTH(32), .DEPTH(32), .LINK_REG(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .link_en   (link_en),
    .link_data (link_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D; rs_addr = 5'd9; rt_addr = 5'd9;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_write_ignored: got %h expected %h", rs_data, 32'h0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #1;
      vectors++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_read a=%0d: rs=%h rt=%h expected 0", a, rs_data, rt_data);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
    vectors++;
    if (rs_data !== 32'h0) begin
      miscompares++;
      $display("FAIL read_before_write: got %h expected %h", rs_data, 32'h0);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'hDEADBEEF || rt_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_reg5: rs=%h rt=%h expected %h", rs_data, rt_data, 32'hDEADBEEF);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs_addr = 5'd0; rt_addr = 5'd0;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_reg: rs=%h rt=%h expected 0", rs_data, rt_data);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_link();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h11111111;
    link_en = 1'b1; link_data = 32'h00000040; rs_addr = 5'd31; rt_addr = 5'd7;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h00000040) begin
      miscompares++;
      $display("FAIL link_collision: got %h expected %h", rs_data, 32'h00000040);
    end
    @(negedge clk);
    link_en = 1'b0; wr_addr = 5'd31; wr_data = 32'h22222222;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h22222222) begin
      miscompares++;
      $display("FAIL writeback_reg31: got %h expected %h", rs_data, 32'h22222222);
    end
    @(negedge clk);
    wr_addr = 5'd7; wr_data = 32'h11111111; link_en = 1'b1; link_data = 32'h00000040;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h00000040 || rt_data !== 32'h11111111) begin
      miscompares++;
      $display("FAIL dual_write: reg31=%h reg7=%h expected %h %h",
               rs_data, rt_data, 32'h00000040, 32'h11111111);
    end
    @(negedge clk);
    wr_en = 1'b0; link_en = 1'b0; wr_data = 32'h55555555; link_data = 32'h66666666;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h00000040 || rt_data !== 32'h11111111) begin
      miscompares++;
      $display("FAIL hold: reg31=%h reg7=%h expected %h %h",
               rs_data, rt_data, 32'h00000040, 32'h11111111);
    end
    rs_addr = 5'd5;
    #1;
    vectors++;
    if (rs_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL hold_reg5: got %h expected %h", rs_data, 32'hDEADBEEF);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; rs_addr = 5'd3; rt_addr = 5'd31;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL write_reg3: got %h expected %h", rs_data, 32'hA5A5A5A5);
    end
    wr_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_clear: reg3=%h reg31=%h expected 0", rs_data, rt_data);
    end
    wr_en = 1'b1; wr_data = 32'h12345678;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h0) begin
      miscompares++;
      $display("FAIL write_in_reset: got %h expected %h", rs_data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (rs_data !== 32'h12345678) begin
      miscompares++;
      $display("FAIL first_write_after_reset: got %h expected %h", rs_data, 32'h12345678);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] model [32];
    int          bad;
    bad = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      wr_en     = ($urandom_range(0, 3) != 0);
      link_en   = ($urandom_range(0, 7) == 0);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      link_data = $urandom;
      rs_addr   = 5'($urandom_range(0, 31));
      rt_addr   = (c % 5 == 0) ? rs_addr : 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (rs_data !== model[rs_addr] || rt_data !== model[rt_addr]) begin
        miscompares++;
        bad++;
        if (bad <= 10) begin
          $display("FAIL random c=%0d: rs[%0d]=%h exp %h rt[%0d]=%h exp %h", c,
                   rs_addr, rs_data, model[rs_addr], rt_addr, rt_data, model[rt_addr]);
        end
      end
      if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
      if (link_en) model[31] = link_data;
    end
    @(negedge clk);
    wr_en = 1'b0; link_en = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    link_en = 1'b0; link_data = 32'h0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_link();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
